// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_pkg
// Brief    : Shared constants and state encoding for irq_pending_ctrl.
// Revision : 1.0
// ============================================================================
package irq_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } irq_state_e;

endpackage : irq_pkg
`default_nettype wire

// File: rtl/prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc
// Brief    : Combinational N-to-IDX_W priority encoder, highest index wins.
// Revision : 1.0
// ============================================================================
module prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Ascending scan so the last (highest) set bit overrides lower ones.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |req;

endmodule : prio_enc
`default_nettype wire

// File: rtl/irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_pending_ctrl
// Brief    : Edge-captured pending register with mask, priority selection and
//            valid/ack presentation. Define IRQ_SYNC_EN to insert a 2-flop
//            synchronizer on every irq_in bit ahead of edge detection.
// Revision : 1.0
// ============================================================================
module irq_pending_ctrl
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     irq_in,
    input  logic [N-1:0]     mask,
    output logic             irq_valid,
    output logic [IDX_W-1:0] irq_id,
    input  logic             irq_ack,
    output logic [N-1:0]     pending
);

    logic [N-1:0]     w_irq_s;
    logic [N-1:0]     w_edge;
    logic [N-1:0]     w_cand;
    logic [IDX_W-1:0] w_sel;
    logic             w_any;
    logic             w_ack_fire;

    logic [N-1:0]     r_prev_q,    w_prev_d;
    logic [N-1:0]     r_pending_q, w_pending_d;
    logic             r_valid_q,   w_valid_d;
    logic [IDX_W-1:0] r_id_q,      w_id_d;
    irq_state_e       r_state_q,   w_state_d;

`ifdef IRQ_SYNC_EN
    logic [N-1:0] r_sync1_q, w_sync1_d;
    logic [N-1:0] r_sync2_q, w_sync2_d;

    always_comb begin
        w_sync1_d = irq_in;
        w_sync2_d = r_sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1_q <= '0;
            r_sync2_q <= '0;
        end else begin
            r_sync1_q <= w_sync1_d;
            r_sync2_q <= w_sync2_d;
        end
    end

    assign w_irq_s = r_sync2_q;
`else
    assign w_irq_s = irq_in;
`endif

    assign w_edge     = w_irq_s & ~r_prev_q;
    assign w_cand     = r_pending_q & mask;
    assign w_ack_fire = (r_state_q == BUSY) && irq_ack;

    prio_enc #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req (w_cand),
        .idx (w_sel),
        .any (w_any)
    );

    // Clear is applied before the edge OR so a same-cycle re-edge keeps the bit set.
    always_comb begin
        w_prev_d    = w_irq_s;
        w_pending_d = r_pending_q;
        if (w_ack_fire) begin
            w_pending_d[r_id_q] = 1'b0;
        end
        w_pending_d = w_pending_d | w_edge;
    end

    always_comb begin
        w_state_d = r_state_q;
        w_valid_d = r_valid_q;
        w_id_d    = r_id_q;
        case (r_state_q)
            IDLE: begin
                w_valid_d = 1'b0;
                if (en && w_any) begin
                    w_id_d    = w_sel;
                    w_valid_d = 1'b1;
                    w_state_d = BUSY;
                end
            end
            BUSY: begin
                if (irq_ack) begin
                    w_valid_d = 1'b0;
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_valid_d = 1'b0;
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_q    <= '0;
            r_pending_q <= '0;
            r_valid_q   <= 1'b0;
            r_id_q      <= '0;
            r_state_q   <= IDLE;
        end else begin
            r_prev_q    <= w_prev_d;
            r_pending_q <= w_pending_d;
            r_valid_q   <= w_valid_d;
            r_id_q      <= w_id_d;
            r_state_q   <= w_state_d;
        end
    end

    assign irq_valid = r_valid_q;
    assign irq_id    = r_id_q;
    assign pending   = r_pending_q;

endmodule : irq_pending_ctrl
`default_nettype wire

// File: tb/tb_irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_pending_ctrl
// Brief    : Self-checking bench for irq_pending_ctrl: directed scenarios plus
//            randomized traffic against an event-level reference model.
// Revision : 1.0
// ============================================================================
module tb_irq_pending_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int LAT    = 4;
    localparam int SYNC_D = 2;
`else
    localparam int LAT    = 2;
    localparam int SYNC_D = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] irq_in = '0;
    logic [7:0] mask = '0;
    logic       irq_ack = 1'b0;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic [7:0] pending;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    irq_pending_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .irq_in    (irq_in),
        .mask      (mask),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // Reference model: per-line event flags and one presentation slot.
    bit m_pend [8];
    bit m_prev [8];
    bit m_s1   [8];
    bit m_s2   [8];
    bit m_seen [8];
    bit m_np   [8];
    bit m_valid = 1'b0;
    int m_id    = 0;
    int m_best;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                m_pend[k] = 1'b0; m_prev[k] = 1'b0;
                m_s1[k]   = 1'b0; m_s2[k]   = 1'b0;
            end
            m_valid = 1'b0;
            m_id    = 0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                m_seen[k] = (SYNC_D > 0) ? m_s2[k] : irq_in[k];
                m_s2[k]   = m_s1[k];
                m_s1[k]   = irq_in[k];
            end
            for (int k = 0; k < 8; k++) begin
                if (m_seen[k] && !m_prev[k])
                    m_np[k] = 1'b1;
                else if (m_valid && irq_ack && (k == m_id))
                    m_np[k] = 1'b0;
                else
                    m_np[k] = m_pend[k];
            end
            if (m_valid) begin
                if (irq_ack) m_valid = 1'b0;
            end else if (en) begin
                m_best = -1;
                for (int k = 0; k < 8; k++)
                    if (m_pend[k] && mask[k]) m_best = k;
                if (m_best >= 0) begin
                    m_valid = 1'b1;
                    m_id    = m_best;
                end
            end
            for (int k = 0; k < 8; k++) begin
                m_pend[k] = m_np[k];
                m_prev[k] = m_seen[k];
            end
        end
    end

    function automatic logic [7:0] model_pending();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = m_pend[k];
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            n_tests++;
            if (irq_valid !== m_valid) begin
                n_fail++;
                $display("FAIL model_valid @%0t: got %0b expected %0b", $time, irq_valid, m_valid);
            end
            n_tests++;
            if (pending !== model_pending()) begin
                n_fail++;
                $display("FAIL model_pending @%0t: got 0x%0h expected 0x%0h", $time, pending, model_pending());
            end
            if (m_valid) begin
                n_tests++;
                if (irq_id !== 3'(m_id)) begin
                    n_fail++;
                    $display("FAIL model_id @%0t: got %0d expected %0d", $time, irq_id, m_id);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input string nm, output int k);
        k = 0;
        while (irq_valid !== 1'b1 && k < 20) begin
            cyc();
            k++;
        end
        if (irq_valid !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got valid=%0b expected 1 within 20 cycles", nm, irq_valid);
        end
    endtask

    task automatic pulse(input logic [7:0] v);
        irq_in = v;
        cyc();
        irq_in = '0;
    endtask

    task automatic ack_once();
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
    endtask

    int k;

    initial begin
        rst = 1'b1;
        cyc();
        chk_on = 1'b1;
        cyc();
        rst = 1'b0;
        chk("reset_pending", 32'(pending), 32'h00);
        chk("reset_valid",   32'(irq_valid), 32'h0);
        chk("reset_id",      32'(irq_id), 32'h0);

        // Single request on bit 4
        mask = 8'hFF;
        en   = 1'b1;
        pulse(8'h10);
        wait_valid("c1", k);
        chk("c1_latency", 32'(k + 1), 32'(LAT));
        chk("c1_id", 32'(irq_id), 32'd4);
        ack_once();
        chk("c1_ack_valid", 32'(irq_valid), 32'h0);
        chk("c1_ack_pending", 32'(pending), 32'h00);

        // Simultaneous edges on bits 7 and 1
        pulse(8'h82);
        wait_valid("c2a", k);
        chk("c2_first_id", 32'(irq_id), 32'd7);
        ack_once();
        chk("c2_gap_valid", 32'(irq_valid), 32'h0);
        chk("c2_gap_pending", 32'(pending), 32'h02);
        cyc();
        chk("c2_second_valid", 32'(irq_valid), 32'h1);
        chk("c2_second_id", 32'(irq_id), 32'd1);
        ack_once();
        chk("c2_done_pending", 32'(pending), 32'h00);

        // Masked request is held pending until unmasked
        mask = 8'h7F;
        pulse(8'h80);
        repeat (LAT) cyc();
        chk("c3_masked_valid", 32'(irq_valid), 32'h0);
        chk("c3_masked_pending", 32'(pending), 32'h80);
        mask = 8'hFF;
        wait_valid("c3", k);
        chk("c3_id", 32'(irq_id), 32'd7);
        ack_once();

        // New higher edge while BUSY does not disturb the presented id
        pulse(8'h08);
        wait_valid("c4a", k);
        chk("c4_first_id", 32'(irq_id), 32'd3);
        pulse(8'h40);
        repeat (LAT) cyc();
        chk("c4_hold_valid", 32'(irq_valid), 32'h1);
        chk("c4_hold_id", 32'(irq_id), 32'd3);
        chk("c4_hold_pending", 32'(pending), 32'h48);
        ack_once();
        cyc();
        chk("c4_next_id", 32'(irq_id), 32'd6);
        ack_once();

        // Ack coincident with a new edge on the same bit
        pulse(8'h04);
        wait_valid("c5a", k);
        chk("c5_first_id", 32'(irq_id), 32'd2);
        irq_in = 8'h04;
        for (int i = 0; i < SYNC_D; i++) begin
            cyc();
            irq_in = '0;
        end
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        irq_in  = '0;
        chk("c5_set_wins_pending", 32'(pending), 32'h04);
        cyc();
        chk("c5_represent_valid", 32'(irq_valid), 32'h1);
        chk("c5_represent_id", 32'(irq_id), 32'd2);
        ack_once();

        // Reset in the middle of a handshake
        pulse(8'h21);
        wait_valid("c6", k);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("c6_rst_valid", 32'(irq_valid), 32'h0);
        chk("c6_rst_pending", 32'(pending), 32'h00);
        cyc();
        chk("c6_after_valid", 32'(irq_valid), 32'h0);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            irq_in  = irq_in ^ 8'($urandom & $urandom & $urandom);
            if ((i % 50) == 0) mask = 8'($urandom | $urandom);
            en      = ($urandom_range(0, 7) != 0);
            irq_ack = ($urandom_range(0, 2) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst     = 1'b0;
        irq_ack = 1'b0;
        cyc();
        chk_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_irq_pending_ctrl
`default_nettype wire
